poly_tone_gen: RTL

Parametrised polyphonic square-wave tone generator: the multi-voice successor of the single-voice note player. Each of `VOICES` voices accepts a note code and duration over a valid/ready port and plays the note for that many duration ticks. Voice outputs are mixed into a 1-bit first-order sigma-delta stream for the AMP2 audio pin. It sits between the song ROM sequencer and the board audio pins.

---
 rtl/poly_tone_gen.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave tone generator with a 1-bit first-order sigma-delta mix.
// Define POLY_TONE_RETRIGGER_EN to let a load restart a voice that is still busy.
module poly_tone_gen #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned VOICES  = 2,
  parameter int unsigned DUR_W   = 8,
  parameter int unsigned TICK_HZ = 64,
  localparam int unsigned VW     = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              pause,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VW-1:0]     in_voice,
  input  logic [6:0]        in_note,
  input  logic [DUR_W-1:0]  in_dur,
  output logic [VOICES-1:0] voice_busy,
  output logic [VOICES-1:0] voice_sq,
  output logic              audio_out,
  output logic              amp_en
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HP_W     = $clog2(CLK_HZ / 220 + 1);
  localparam int unsigned EW       = $clog2(VOICES) + 1;
  localparam int unsigned AW       = EW + 1;
  localparam int unsigned SW       = $clog2(VOICES + 1);

  // Octave-0 half periods, semitones A..Ab at 110..208 Hz.
  localparam int unsigned HP0 [12] = '{
    CLK_HZ / 220, CLK_HZ / 234, CLK_HZ / 246, CLK_HZ / 262,
    CLK_HZ / 278, CLK_HZ / 294, CLK_HZ / 312, CLK_HZ / 330,
    CLK_HZ / 350, CLK_HZ / 370, CLK_HZ / 392, CLK_HZ / 416
  };

  typedef enum logic {StIdle, StPlay} vstate_e;

  vstate_e           state_q [VOICES];
  vstate_e           state_d [VOICES];
  logic [HP_W-1:0]   tone_q  [VOICES];
  logic [HP_W-1:0]   hp_q    [VOICES];
  logic [DUR_W-1:0]  dur_q   [VOICES];
  logic [VOICES-1:0] rest_q;
  logic [VOICES-1:0] sq_q;
  logic [VOICES-1:0] load;

  logic [PW-1:0]     presc_q;
  logic              tick;
  logic [EW-1:0]     e_q;
  logic              audio_q;
  logic              amp_q;

  logic [3:0]        oct;
  logic [3:0]        semi;
  logic              rest_note;
  logic [HP_W-1:0]   hp_new;
  logic              in_range;
  logic              busy_sel;
  logic              accept;
  logic [SW-1:0]     pop;
  logic [AW-1:0]     e_sum;

  // Note decode and half-period lookup for the incoming load.
  always_comb begin
    oct       = 4'(in_note / 7'd12);
    semi      = 4'(in_note % 7'd12);
    rest_note = (in_note == 7'd0) || (in_note >= 7'd72);
    hp_new    = HP_W'(HP0[semi] >> oct);
  end

  assign in_range = 32'(in_voice) < VOICES;
  assign busy_sel = in_range ? voice_busy[in_voice] : 1'b0;

`ifdef POLY_TONE_RETRIGGER_EN
  assign in_ready = ~pause;
`else
  assign in_ready = ~pause & ~busy_sel;
`endif

  // Loads aimed past the last voice are accepted and dropped.
  assign accept = in_valid & in_ready & in_range;

  always_comb begin
    load = '0;
    for (int v = 0; v < VOICES; v++) begin
      load[v] = accept && (in_voice == VW'(v));
    end
  end

  // Global prescaler; never restarted by loads.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      presc_q <= '0;
    end else if (!pause) begin
      presc_q <= (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
    end
  end

  assign tick = ~pause & (presc_q == PW'(TICK_DIV - 1));

  // Voice FSM: state register.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int v = 0; v < VOICES; v++) state_q[v] <= StIdle;
    end else begin
      for (int v = 0; v < VOICES; v++) state_q[v] <= state_d[v];
    end
  end

  // Voice FSM: next state. A reload on the expiry cycle keeps the voice playing.
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      state_d[v] = state_q[v];
      if (load[v]) begin
        state_d[v] = StPlay;
      end else if (state_q[v] == StPlay && tick && dur_q[v] == DUR_W'(1)) begin
        state_d[v] = StIdle;
      end
    end
  end

  // Voice FSM: outputs.
  always_comb begin
    voice_busy = '0;
    for (int v = 0; v < VOICES; v++) begin
      voice_busy[v] = (state_q[v] == StPlay);
    end
  end

  // Per-voice tone and duration counters.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sq_q   <= '0;
      rest_q <= '0;
      for (int v = 0; v < VOICES; v++) begin
        tone_q[v] <= '0;
        hp_q[v]   <= '0;
        dur_q[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (load[v]) begin
          tone_q[v] <= hp_new - HP_W'(1);
          hp_q[v]   <= hp_new;
          dur_q[v]  <= in_dur;
          rest_q[v] <= rest_note;
          sq_q[v]   <= 1'b0;
        end else if (state_d[v] == StIdle) begin
          sq_q[v] <= 1'b0;
        end else if (!pause) begin
          if (tone_q[v] == '0) begin
            tone_q[v] <= hp_q[v] - HP_W'(1);
            if (!rest_q[v]) sq_q[v] <= ~sq_q[v];
          end else begin
            tone_q[v] <= tone_q[v] - HP_W'(1);
          end
          if (tick && dur_q[v] != '0) dur_q[v] <= dur_q[v] - DUR_W'(1);
        end
      end
    end
  end

  assign voice_sq = sq_q;

  always_comb begin
    pop = '0;
    for (int v = 0; v < VOICES; v++) begin
      pop = pop + SW'(sq_q[v]);
    end
    e_sum = AW'(e_q) + AW'(pop);
  end

  // First-order sigma-delta: emit 1 whenever the accumulator reaches full scale.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      e_q     <= '0;
      audio_q <= 1'b0;
    end else if (pause) begin
      audio_q <= 1'b0;
    end else if (e_sum >= AW'(VOICES)) begin
      audio_q <= 1'b1;
      e_q     <= EW'(e_sum - AW'(VOICES));
    end else begin
      audio_q <= 1'b0;
      e_q     <= EW'(e_sum);
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      amp_q <= 1'b0;
    end else begin
      amp_q <= ~pause;
    end
  end

  assign audio_out = audio_q;
  assign amp_en    = amp_q;

endmodule
